// File: rtl/bitmap_line_scheduler.sv
// bitmap_line_scheduler
// Fetches one bitmap line per request from a single-port 1-bit ROM into the
// back half of a ping-pong line buffer. Scanout reads the front half at pixel
// rate without touching the ROM. Display lags requests by one line.
//
// Optional feature macro: BITMAP_SCHED_BLANK_EN
//   defined     : line_y >= HEIGHT fetches a blank line (rom_y held at 0,
//                 every written pixel forced to 0)
//   not defined : rom_y = line_y mod HEIGHT (bitmap repeats vertically)
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   line_start   one-cycle pulse: swap buffers, start fetching line_y
//   line_y       line to fetch, sampled with line_start
//   rom_x/rom_y  ROM address (owned exclusively by this block)
//   rom_pixel    ROM data, valid one cycle after the address
//   rd_x         scanout pixel index
//   rd_pixel     registered front-buffer pixel at rd_x
//   fetch_busy   back-buffer fill in progress
//   overrun      sticky: line_start arrived before the fetch completed
//   overrun_clr  clears overrun (a simultaneous set wins)
module bitmap_line_scheduler #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned HEIGHT     = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [ADDR_WIDTH-1:0] line_y,
  output logic [ADDR_WIDTH-1:0] rom_x,
  output logic [ADDR_WIDTH-1:0] rom_y,
  input  logic                  rom_pixel,
  input  logic [ADDR_WIDTH-1:0] rd_x,
  output logic                  rd_pixel,
  output logic                  fetch_busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   rom_x_d, rom_y_d;
  logic                    front, front_d;
  logic                    front_valid, front_valid_d;
  logic                    back_done, back_done_d;
  logic                    busy_d;
  logic                    overrun_d;
  logic                    wr_valid, wr_valid_d;
  logic [XW-1:0]           wr_x;
  logic                    wr_en_c;
  logic                    wr_data_c;
  logic                    back_sel_c;
  logic                    rd_in_range_c;
  logic                    line_buf [2][WIDTH];

`ifdef BITMAP_SCHED_BLANK_EN
  logic                    blank, blank_d;
`endif

  // Next-state and next-register values; line_start overrides everything,
  // including a fetch in progress (abort).
  always_comb begin
    state_d       = state;
    rom_x_d       = rom_x;
    rom_y_d       = rom_y;
    front_d       = front;
    front_valid_d = front_valid;
    back_done_d   = back_done;
    busy_d        = fetch_busy;
    overrun_d     = overrun & ~overrun_clr;
    wr_valid_d    = 1'b0;
`ifdef BITMAP_SCHED_BLANK_EN
    blank_d       = blank;
`endif

    case (state)
      IDLE: begin
      end
      FETCH: begin
        // rom_x presented this cycle returns next cycle; remember it for the write.
        wr_valid_d = 1'b1;
        if (rom_x == ADDR_WIDTH'(WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          rom_x_d = rom_x + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d     = IDLE;
        back_done_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (line_start) begin
      if (state != IDLE) begin
        overrun_d = 1'b1;
      end
      front_d       = ~front;
      // An aborted fetch never set back_done, so the new front is invalid.
      front_valid_d = (state == IDLE) ? back_done : 1'b0;
      back_done_d   = 1'b0;
      rom_x_d       = '0;
      state_d       = FETCH;
      busy_d        = 1'b1;
      wr_valid_d    = 1'b0;
`ifdef BITMAP_SCHED_BLANK_EN
      if (line_y >= ADDR_WIDTH'(HEIGHT)) begin
        rom_y_d = '0;
        blank_d = 1'b1;
      end else begin
        rom_y_d = line_y;
        blank_d = 1'b0;
      end
`else
      rom_y_d = line_y % ADDR_WIDTH'(HEIGHT);
`endif
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_x       <= '0;
      rom_y       <= '0;
      front       <= 1'b0;
      front_valid <= 1'b0;
      back_done   <= 1'b0;
      fetch_busy  <= 1'b0;
      overrun     <= 1'b0;
      wr_valid    <= 1'b0;
      wr_x        <= '0;
`ifdef BITMAP_SCHED_BLANK_EN
      blank       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      rom_x       <= rom_x_d;
      rom_y       <= rom_y_d;
      front       <= front_d;
      front_valid <= front_valid_d;
      back_done   <= back_done_d;
      fetch_busy  <= busy_d;
      overrun     <= overrun_d;
      wr_valid    <= wr_valid_d;
      wr_x        <= rom_x[XW-1:0];
`ifdef BITMAP_SCHED_BLANK_EN
      blank       <= blank_d;
`endif
    end
  end

  // Back-buffer write; the pending pixel of an aborted or reset fetch is dropped.
  assign back_sel_c = ~front;
  assign wr_en_c    = wr_valid & ~line_start & rst_n;
`ifdef BITMAP_SCHED_BLANK_EN
  assign wr_data_c  = rom_pixel & ~blank;
`else
  assign wr_data_c  = rom_pixel;
`endif

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      line_buf[back_sel_c][wr_x] <= wr_data_c;
    end
  end

  // Scanout read from the front buffer, registered.
  assign rd_in_range_c = (rd_x < ADDR_WIDTH'(WIDTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pixel <= 1'b0;
    end else begin
      rd_pixel <= front_valid & rd_in_range_c & line_buf[front][rd_x[XW-1:0]];
    end
  end

endmodule

// File: tb/tb_bitmap_line_scheduler.sv
// Directed self-checking bench for bitmap_line_scheduler with a behavioural
// 1-cycle-latency ROM. Expected pixels come from rom_fn below.
module tb_bitmap_line_scheduler;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst_n;
  logic          line_start;
  logic [AW-1:0] line_y;
  logic [AW-1:0] rom_x;
  logic [AW-1:0] rom_y;
  logic          rom_pixel;
  logic [AW-1:0] rd_x;
  logic          rd_pixel;
  logic          fetch_busy;
  logic          overrun;
  logic          overrun_clr;

  int checks = 0;
  int passes = 0;

  bitmap_line_scheduler #(.ADDR_WIDTH(10), .WIDTH(256), .HEIGHT(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_start  (line_start),
    .line_y      (line_y),
    .rom_x       (rom_x),
    .rom_y       (rom_y),
    .rom_pixel   (rom_pixel),
    .rd_x        (rd_x),
    .rd_pixel    (rd_pixel),
    .fetch_busy  (fetch_busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitmap content: row 5 alternates 1,0; other rows are a mixed pattern.
  function automatic logic rom_fn(input logic [AW-1:0] y, input logic [AW-1:0] x);
    if (y == 10'd5) return ~x[0];
    return x[1] ^ x[3] ^ y[0] ^ (x[4] & y[1]) ^ (x[2] & y[2]);
  endfunction

  always @(posedge clk) rom_pixel <= rom_fn(rom_y, rom_x);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int y);
    line_y     = AW'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (fetch_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) $display("FAIL idle_timeout busy=%0b after %0d cycles", fetch_busy, n);
    else passes++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (fetch_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", fetch_busy); else passes++;
    checks++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun got %0b exp 0", overrun); else passes++;
    checks++;
    if (rom_x !== 10'd0 || rom_y !== 10'd0)
      $display("FAIL reset_addr got x=%0d y=%0d exp 0,0", rom_x, rom_y);
    else passes++;
    for (int k = 0; k < 256; k++) begin
      rd_x = AW'(k);
      tick();
      checks++;
      if (rd_pixel !== 1'b0) $display("FAIL reset_rd x=%0d got %0b exp 0", k, rd_pixel); else passes++;
    end
    checks++;
    if (fetch_busy !== 1'b0) $display("FAIL reset_busy_after got %0b exp 0", fetch_busy); else passes++;
  endtask

  task automatic test_fetch;
    int cnt = 0;
    int ex;
    rd_x = '0;
    pulse(5);
    checks++;
    if (rom_y !== 10'd5) $display("FAIL fetch_rom_y got %0d exp 5", rom_y); else passes++;
    while (fetch_busy === 1'b1 && cnt < 400) begin
      ex = (cnt > 255) ? 255 : cnt;
      checks++;
      if (rom_x !== AW'(ex)) $display("FAIL fetch_rom_x cyc=%0d got %0d exp %0d", cnt, rom_x, ex);
      else passes++;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 257) $display("FAIL busy_len got %0d exp 257", cnt); else passes++;
    checks++;
    if (rd_pixel !== 1'b0) $display("FAIL pre_swap_rd got %0b exp 0", rd_pixel); else passes++;
    pulse(6);
    checks++;
    if (overrun !== 1'b0) $display("FAIL spacing_overrun got %0b exp 0", overrun); else passes++;
    for (int k = 0; k < 256; k++) begin
      rd_x = AW'(k);
      tick();
      checks++;
      if (rd_pixel !== ((k % 2) == 0)) $display("FAIL row5_rd x=%0d got %0b exp %0b", k, rd_pixel, (k % 2) == 0);
      else passes++;
    end
    rd_x = AW'(300);
    tick();
    checks++;
    if (rd_pixel !== 1'b0) $display("FAIL rd_out_of_range got %0b exp 0", rd_pixel); else passes++;
    wait_idle();
  endtask

  task automatic test_overrun;
    logic ex;
    pulse(7);
    rd_x = AW'(1);
    tick();
    ex = rom_fn(10'd6, 10'd1);
    checks++;
    if (rd_pixel !== ex) $display("FAIL row6_rd got %0b exp %0b", rd_pixel, ex); else passes++;
    repeat (98) tick();
    checks++;
    if (overrun !== 1'b0) $display("FAIL pre_overrun got %0b exp 0", overrun); else passes++;
    pulse(8);
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got %0b exp 1", overrun); else passes++;
    checks++;
    if (fetch_busy !== 1'b1 || rom_x !== 10'd0)
      $display("FAIL overrun_restart got busy=%0b x=%0d exp 1,0", fetch_busy, rom_x);
    else passes++;
    for (int k = 0; k < 256; k++) begin
      rd_x = AW'(k);
      tick();
      checks++;
      if (rd_pixel !== 1'b0) $display("FAIL aborted_rd x=%0d got %0b exp 0", k, rd_pixel); else passes++;
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clr got %0b exp 0", overrun); else passes++;
    wait_idle();
  endtask

  task automatic test_wrap;
    logic          ex;
    logic [AW-1:0] ey;
`ifdef BITMAP_SCHED_BLANK_EN
    ey = '0;
`else
    ey = AW'(2);
`endif
    pulse(130);
    checks++;
    if (rom_y !== ey) $display("FAIL wrap_rom_y got %0d exp %0d", rom_y, ey); else passes++;
    wait_idle();
    pulse(0);
    for (int k = 0; k < 256; k++) begin
      rd_x = AW'(k);
      tick();
`ifdef BITMAP_SCHED_BLANK_EN
      ex = 1'b0;
`else
      ex = rom_fn(10'd2, AW'(k));
`endif
      checks++;
      if (rd_pixel !== ex) $display("FAIL wrap_rd x=%0d got %0b exp %0b", k, rd_pixel, ex); else passes++;
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    pulse(3);
    repeat (49) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (fetch_busy !== 1'b0 || rom_x !== 10'd0)
      $display("FAIL midreset got busy=%0b x=%0d exp 0,0", fetch_busy, rom_x);
    else passes++;
    checks++;
    if (rd_pixel !== 1'b0 || overrun !== 1'b0)
      $display("FAIL midreset_out got rd=%0b ovr=%0b exp 0,0", rd_pixel, overrun);
    else passes++;
    rst_n = 1'b1;
    tick();
    pulse(5);
    while (fetch_busy === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 257) $display("FAIL post_reset_busy_len got %0d exp 257", cnt); else passes++;
    pulse(9);
    for (int k = 0; k < 16; k++) begin
      rd_x = AW'(k);
      tick();
      checks++;
      if (rd_pixel !== ((k % 2) == 0)) $display("FAIL post_reset_rd x=%0d got %0b exp %0b", k, rd_pixel, (k % 2) == 0);
      else passes++;
    end
  endtask

  task automatic test_same_edge;
    checks++;
    if (overrun !== 1'b0 || fetch_busy !== 1'b1)
      $display("FAIL same_edge_pre got ovr=%0b busy=%0b exp 0,1", overrun, fetch_busy);
    else passes++;
    overrun_clr = 1'b1;
    pulse(10);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) $display("FAIL set_wins got %0b exp 1", overrun); else passes++;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) $display("FAIL same_edge_clr got %0b exp 0", overrun); else passes++;
    wait_idle();
  endtask

  initial begin
    rst_n       = 1'b0;
    line_start  = 1'b0;
    line_y      = '0;
    rd_x        = '0;
    overrun_clr = 1'b0;
    test_reset();
    test_fetch();
    test_overrun();
    test_wrap();
    test_reset_mid();
    test_same_edge();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bitmap_line_scheduler.md
# bitmap_line_scheduler

Sequences reads of the single-port 1-bit bitmap ROM, one line per request, into a ping-pong line buffer. Scanout then reads pixels from the buffer at LCD pixel rate without touching the ROM. The block sits between the LCD timing generator (line requests, scanout x) and the bitmap ROM (x/y address in, registered pixel out with 1-cycle latency). It owns the ROM address bus exclusively.

## Interface
- `ADDR_WIDTH`, 10, width of all x/y coordinates
- `WIDTH`, 256, bitmap pixels per line; line buffer depth
- `HEIGHT`, 128, bitmap lines

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `line_start`  in  1  one-cycle pulse: swap buffers, begin fetching line `line_y`
- `line_y`  in  ADDR_WIDTH  line to fetch; sampled only with `line_start`
- `rom_x`  out  ADDR_WIDTH  ROM x address
- `rom_y`  out  ADDR_WIDTH  ROM y address
- `rom_pixel`  in  1  ROM data, valid 1 cycle after address presented
- `rd_x`  in  ADDR_WIDTH  scanout pixel index
- `rd_pixel`  out  1  front-buffer pixel at `rd_x`, registered
- `fetch_busy`  out  1  back-buffer fill in progress
- `overrun`  out  1  sticky: `line_start` arrived before fetch completed
- `overrun_clr`  in  1  clears `overrun`

## Operation
- Two WIDTH×1 buffers. Select bit `front` picks the scanout buffer; the other is the back buffer.
- FSM: IDLE → FETCH → DRAIN → IDLE.
  - IDLE + `line_start`: toggle `front`. `front_valid` ← `back_done`, then `back_done` ← 0. `rom_y` ← `line_y`, `rom_x` ← 0, go to FETCH.
  - FETCH: `rom_x` increments each cycle. After presenting `WIDTH-1`, go to DRAIN and hold `rom_x`.
  - DRAIN: one cycle to write the final pixel. Set `back_done`, go to IDLE.
- Write path: the pixel for x is captured from `rom_pixel` one cycle after x is presented. It is written to `back[x]` on the following edge using a 1-cycle delayed copy of `rom_x` plus a write-valid bit.
- `line_start` in FETCH or DRAIN: abort the fetch and set `overrun`. Do not set `back_done`. Perform the IDLE + `line_start` actions in the same cycle, so `front_valid` becomes 0. Suppress the pending write of the aborted fetch.
- `line_start` and `overrun_clr` in the same cycle: `overrun` ends set (set wins).
- `rd_pixel` ← 0 if `!front_valid` or `rd_x >= WIDTH`; otherwise ← `front[rd_x]`.
- `rom_x` and `rom_y` never exceed `WIDTH-1` and `HEIGHT-1`, so the ROM address `y*WIDTH+x` stays in range.
- Reset (`rst_n`=0 at an edge): state IDLE, `front`=0, `front_valid`=0, `back_done`=0, `rom_x`=0, `rom_y`=0, `rd_pixel`=0, `fetch_busy`=0, `overrun`=0, write-valid=0. Buffer contents are not cleared. Reset mid-fetch discards it.

## Timing
- Edge E0 samples `line_start`. At E0: `fetch_busy`=1, `rom_x`=0.
- `rom_x`=k during cycle after E0+k, for k=0..WIDTH-1.
- Pixel k is written at E0+k+2. The last write is at E0+WIDTH+1, and `fetch_busy` drops on that same edge.
- Minimum `line_start` spacing without overrun: WIDTH+2 cycles.
- Line data fetched for request n becomes visible on `rd_pixel` after request n+1. Display therefore lags requests by one line; the timing generator requests line y+1 while showing y.
- `rd_pixel` latency: 1 cycle from `rd_x`. A swap at E0 affects `rd_pixel` from E0+1.

## Configuration
- `BITMAP_SCHED_BLANK_EN` defined: `line_y >= HEIGHT` fetches no ROM data. FSM timing is unchanged, `rom_y` is held at 0, and every written pixel is 0, so the line displays blank.
- Not defined: `rom_y` ← `line_y mod HEIGHT`, so the bitmap repeats vertically.

## Test plan
- Reset, then `rd_x`=0..255 with no request → `rd_pixel`=0 throughout; `fetch_busy`=0; `overrun`=0.
- ROM row 5 = alternating 1,0. Pulse `line_start` with `line_y`=5, wait 258 cycles, then pulse again with `line_y`=6 → `fetch_busy` high for exactly 257 cycles; after the second pulse, `rd_x`=k gives `rd_pixel`=(k even) one cycle later; `rd_x`=300 gives 0.
- Pulses 100 cycles apart → `overrun`=1 at the second edge; next swap shows `rd_pixel`=0 everywhere; `overrun_clr` returns `overrun` to 0.
- `line_y`=130 → with `BITMAP_SCHED_BLANK_EN`, the displayed line is all zeros; without it, the displayed line equals ROM row 2.
- `rst_n`=0 at cycle 50 of a fetch → next cycle `fetch_busy`=0 and `rom_x`=0; a subsequent valid fetch completes normally.
- `line_start` and `overrun_clr` on the same edge during a fetch → `overrun`=1.
